// File: rtl/iob_ila_readout_ctrl_if.sv
// ----------------------------------------------------------------------------
// iob_ila_readout_ctrl_if
// Bundle of the bus-facing signals of the ILA readout sequencer.
//   IOb master leg toward the ILA swreg port:
//     m_avalid_o, m_addr_o, m_wdata_o, m_wstrb_o  (request, sequencer -> swreg)
//     m_ready_i, m_rvalid_i, m_rdata_i            (response, swreg -> sequencer)
//   Stream leg toward the DMA/UART bridge:
//     tdata_o, tvalid_o, tlast_o                  (sequencer -> sink)
//     tready_i                                    (sink -> sequencer)
// Signal names keep the sequencer-side direction suffix on both modports.
// ----------------------------------------------------------------------------
interface iob_ila_readout_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  m_avalid_o;
  logic [ADDR_W-1:0]     m_addr_o;
  logic [DATA_W-1:0]     m_wdata_o;
  logic [DATA_W/8-1:0]   m_wstrb_o;
  logic                  m_ready_i;
  logic                  m_rvalid_i;
  logic [DATA_W-1:0]     m_rdata_i;
  logic [DATA_W-1:0]     tdata_o;
  logic                  tvalid_o;
  logic                  tlast_o;
  logic                  tready_i;

  modport master (
    output m_avalid_o, m_addr_o, m_wdata_o, m_wstrb_o, tdata_o, tvalid_o, tlast_o,
    input  m_ready_i, m_rvalid_i, m_rdata_i, tready_i
  );

  modport slave (
    input  m_avalid_o, m_addr_o, m_wdata_o, m_wstrb_o, tdata_o, tvalid_o, tlast_o,
    output m_ready_i, m_rvalid_i, m_rdata_i, tready_i
  );
endinterface

// File: rtl/iob_ila_readout_ctrl.sv
// ----------------------------------------------------------------------------
// iob_ila_readout_ctrl
// Autonomous readout sequencer for the ILA sample buffer. It reads N_SAMPLES,
// then for every sample writes INDEX, and for every word of that sample writes
// SIGNAL_SELECT and reads SAMPLE_DATA, streaming each word out.
// Ports:
//   clk_i, arst_n_i   clock, asynchronous active-low reset
//   cke_i             clock enable; all state holds while low
//   start_i           begins a readout (only honoured in IDLE)
//   abort_i           stops after the in-flight bus transaction / stream beat
//   busy_o, done_o    not-IDLE flag, one-cycle completion pulse
//   dbg_state_o       current FSM state encoding
//   bus               IOb master + stream source (iob_ila_readout_ctrl_if)
// Handshakes: an IOb request (avalid, addr, wdata, wstrb) is held until the
// cycle m_ready_i is 1; writes complete on that ready, reads complete on the
// first m_rvalid_i after it, with one transaction outstanding at a time. A
// stream beat transfers in a cycle where tvalid_o and tready_i are both 1;
// tdata_o/tlast_o are held while tvalid_o is 1 and tready_i is 0.
// ----------------------------------------------------------------------------
module iob_ila_readout_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int SIGNAL_W = 64,
  parameter int BUFFER_W = 5,
  parameter logic [ADDR_W-1:0] ADDR_N_SAMPLES     = 5'h10,
  parameter logic [ADDR_W-1:0] ADDR_INDEX         = 5'h14,
  parameter logic [ADDR_W-1:0] ADDR_SIGNAL_SELECT = 5'h0C,
  parameter logic [ADDR_W-1:0] ADDR_SAMPLE_DATA   = 5'h08
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic       cke_i,
  input  logic       start_i,
  input  logic       abort_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] dbg_state_o,
  iob_ila_readout_ctrl_if.master bus
);

  localparam int N_WORDS_RAW = (SIGNAL_W + DATA_W - 1) / DATA_W;
  localparam int N_WORDS     = (N_WORDS_RAW < 1) ? 1 : N_WORDS_RAW;
  localparam int WORD_W      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [WORD_W-1:0]   LAST_WORD = WORD_W'(N_WORDS - 1);
  localparam logic [BUFFER_W:0]   N_MAX     = {1'b1, {BUFFER_W{1'b0}}};
  localparam logic [BUFFER_W:0]   ONE_N     = (BUFFER_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_N    = 3'd1,
    S_WR_IDX  = 3'd2,
    S_WR_SEL  = 3'd3,
    S_RD_DATA = 3'd4,
    S_PUSH    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic                acc_q, acc_d;      // read accepted, waiting for rvalid
  logic                abort_q, abort_d;
  logic [BUFFER_W:0]   n_q, n_d;
  logic [BUFFER_W-1:0] idx_q, idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;

  logic                avalid;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [BUFFER_W:0]   n_raw, n_clamp;
  logic                abort_hit, last_idx, last_word;

  // A pulse arriving in the same cycle as a check point counts as well.
  assign abort_hit = abort_q | abort_i;
  assign n_raw     = bus.m_rdata_i[BUFFER_W:0];
  assign n_clamp   = (n_raw > N_MAX) ? N_MAX : n_raw;
  assign last_idx  = ({1'b0, idx_q} == (n_q - ONE_N));
  assign last_word = (word_q == LAST_WORD);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= S_IDLE;
      acc_q   <= 1'b0;
      abort_q <= 1'b0;
      n_q     <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      tdata_q <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      abort_q <= abort_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      tdata_q <= tdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    abort_d = abort_q | abort_i;
    n_d     = n_q;
    idx_d   = idx_q;
    word_d  = word_q;
    tdata_d = tdata_q;
    avalid  = 1'b0;
    addr    = '0;
    wdata   = '0;
    wstrb   = '0;
    unique case (state_q)
      S_IDLE: begin
        // Abort in IDLE is dropped, and it also cancels a coincident start.
        abort_d = 1'b0;
        if (start_i && !abort_i) state_d = S_RD_N;
      end
      S_RD_N: begin
        avalid = !acc_q;
        addr   = ADDR_N_SAMPLES;
        if (!acc_q) begin
          if (bus.m_ready_i) acc_d = 1'b1;
        end else if (bus.m_rvalid_i) begin
          acc_d   = 1'b0;
          n_d     = n_clamp;
          idx_d   = '0;
          word_d  = '0;
          state_d = (abort_hit || (n_clamp == '0)) ? S_DONE : S_WR_IDX;
        end
      end
      S_WR_IDX: begin
        avalid = 1'b1;
        addr   = ADDR_INDEX;
        wdata  = DATA_W'(idx_q);
        wstrb  = '1;
        if (bus.m_ready_i) state_d = abort_hit ? S_DONE : S_WR_SEL;
      end
      S_WR_SEL: begin
        avalid = 1'b1;
        addr   = ADDR_SIGNAL_SELECT;
        wdata  = DATA_W'(word_q);
        wstrb  = '1;
        if (bus.m_ready_i) state_d = abort_hit ? S_DONE : S_RD_DATA;
      end
      S_RD_DATA: begin
        avalid = !acc_q;
        addr   = ADDR_SAMPLE_DATA;
        if (!acc_q) begin
          if (bus.m_ready_i) acc_d = 1'b1;
        end else if (bus.m_rvalid_i) begin
          // The word has been fetched, so it is delivered even when aborting;
          // the abort is honoured at the PUSH handshake.
          acc_d   = 1'b0;
          tdata_d = bus.m_rdata_i;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        if (bus.tready_i) begin
          if (abort_hit) begin
            state_d = S_DONE;
          end else if (!last_word) begin
            word_d  = word_q + WORD_W'(1);
            state_d = S_WR_SEL;
          end else if (!last_idx) begin
            idx_d   = idx_q + BUFFER_W'(1);
            word_d  = '0;
            state_d = S_WR_IDX;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.m_avalid_o = avalid;
  assign bus.m_addr_o   = addr;
  assign bus.m_wdata_o  = wdata;
  assign bus.m_wstrb_o  = wstrb;
  assign bus.tdata_o    = tdata_q;
  assign bus.tvalid_o   = (state_q == S_PUSH);
  assign bus.tlast_o    = (state_q == S_PUSH) && last_idx && last_word;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_iob_ila_readout_ctrl.sv
// ----------------------------------------------------------------------------
// tb_iob_ila_readout_ctrl
// Bench for the ILA readout sequencer: a behavioural ILA swreg slave with
// configurable ready/rvalid delays, a stream sink with selectable tready
// pattern, an expected-beat queue filled from a reference sample memory, a
// table of readout scenarios and hand-written corner-case sequences.
// ----------------------------------------------------------------------------
module tb_iob_ila_readout_ctrl;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int SIGNAL_W = 64;
  localparam int BUFFER_W = 5;
  localparam logic [ADDR_W-1:0] A_NS  = 5'h10;
  localparam logic [ADDR_W-1:0] A_IDX = 5'h14;
  localparam logic [ADDR_W-1:0] A_SEL = 5'h0C;
  localparam logic [ADDR_W-1:0] A_DAT = 5'h08;
  localparam logic [2:0] ST_RD_N    = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam int BUDGET = 20000;

  // ---------------- clock / reset ----------------
  logic clk, arst_n, cke, start, abort, busy, done;
  logic [2:0] dbg_state;
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  iob_ila_readout_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  iob_ila_readout_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIGNAL_W(SIGNAL_W), .BUFFER_W(BUFFER_W)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .dbg_state_o(dbg_state), .bus(bus_if)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  logic [DATA_W:0] exp_q[$];   // {tlast, tdata}
  logic [SIGNAL_W-1:0] mem [32];

  // Scenario configuration (written by the main sequence only).
  int n_reg = 0, rdly = 0, rvdly = 1, tr_mode = 0;
  bit slave_en = 1'b1;

  // Observations (written by the monitor only).
  int n_req = 0, n_idx_wr = 0, n_sel_wr = 0, beats = 0;
  int done_cnt = 0, done_cyc = 0, hs_cyc = 0;
  int cur_idx = 0, cur_sel = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- slave + sink + done monitor (negedge) ----------------
  initial begin
    bit rd_pending;
    int rd_cnt, wcnt;
    logic [DATA_W-1:0] rd_val, hold_tdata, hold_wdata;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W:0]   e;
    bit t_stalled, tog;
    rd_pending = 0; rd_cnt = 0; wcnt = 0; t_stalled = 0; tog = 1;
    rd_val = '0; hold_tdata = '0; hold_wdata = '0; hold_addr = '0;
    bus_if.m_ready_i = 0; bus_if.m_rvalid_i = 0; bus_if.m_rdata_i = '0; bus_if.tready_i = 0;
    forever begin
      @(negedge clk);
      bus_if.m_ready_i  = 1'b0;
      bus_if.m_rvalid_i = 1'b0;
      if (!arst_n) begin
        rd_pending = 0; wcnt = 0; t_stalled = 0;
        continue;
      end
      // ILA swreg slave
      if (rd_pending) begin
        if (rd_cnt == 0) begin
          bus_if.m_rvalid_i = 1'b1;
          bus_if.m_rdata_i  = rd_val;
          rd_pending = 0;
        end else rd_cnt--;
      end
      if (bus_if.m_avalid_o && slave_en) begin
        if (wcnt == 0) begin
          hold_addr  = bus_if.m_addr_o;
          hold_wdata = bus_if.m_wdata_o;
        end else begin
          check("addr_hold", bus_if.m_addr_o, hold_addr);
          check("wdata_hold", bus_if.m_wdata_o, hold_wdata);
        end
        if (wcnt >= rdly) begin
          bus_if.m_ready_i = 1'b1;
          wcnt = 0;
          n_req++;
          if (bus_if.m_addr_o == A_IDX || bus_if.m_addr_o == A_SEL)
            check("wstrb_write", bus_if.m_wstrb_o, 4'hF);
          else
            check("wstrb_read", bus_if.m_wstrb_o, 4'h0);
          case (bus_if.m_addr_o)
            A_IDX: begin cur_idx = int'(bus_if.m_wdata_o); n_idx_wr++; end
            A_SEL: begin cur_sel = int'(bus_if.m_wdata_o); n_sel_wr++; end
            default: begin
              rd_pending = 1;
              rd_cnt = rvdly - 1;
              if (bus_if.m_addr_o == A_NS) rd_val = DATA_W'(n_reg);
              else if (bus_if.m_addr_o == A_DAT) rd_val = mem[cur_idx % 32][(cur_sel % 2)*DATA_W +: DATA_W];
              else rd_val = 32'hDEADBEEF;
            end
          endcase
        end else wcnt++;
      end
      // stream sink: mode 0 always ready, 1 toggling 1010, 2 never ready
      case (tr_mode)
        0: bus_if.tready_i = 1'b1;
        1: begin bus_if.tready_i = tog; tog = ~tog; end
        default: bus_if.tready_i = 1'b0;
      endcase
      if (bus_if.tvalid_o) begin
        if (t_stalled) check("tdata_hold", bus_if.tdata_o, hold_tdata);
        if (bus_if.tready_i) begin
          beats++;
          hs_cyc = cyc;
          t_stalled = 0;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL beat_extra: actual beat %0h required none", bus_if.tdata_o);
          end else begin
            e = exp_q.pop_front();
            check("tdata", bus_if.tdata_o, e[DATA_W-1:0]);
            check("tlast", bus_if.tlast_o, e[DATA_W]);
          end
        end else begin
          t_stalled = 1;
          hold_tdata = bus_if.tdata_o;
        end
      end else t_stalled = 0;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int st_cyc = 0;

  task automatic prep(input int nreg, input int rd, input int rv, input int md);
    n_reg = nreg; rdly = rd; rvdly = rv; tr_mode = md;
    n_req = 0; n_idx_wr = 0; n_sel_wr = 0; beats = 0;
  endtask

  task automatic push_model(input int nreg);
    int nn;
    nn = nreg & 'h3F;
    if (nn > 32) nn = 32;
    for (int i = 0; i < nn; i++)
      for (int w = 0; w < 2; w++)
        exp_q.push_back({(i == nn-1) && (w == 1), mem[i][w*DATA_W +: DATA_W]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    st_cyc = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < BUDGET) begin step(1); t++; end
    if (done_cnt == d0) begin
      tests++; fails++;
      $display("FAIL done_timeout: actual no done after %0d cycles required done", BUDGET);
    end
    step(3);
    check("done_pulses", done_cnt - d0, 1);
    check("busy_after", busy, 0);
    check("exp_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_readout(input int nreg, input int rd, input int rv, input int md);
    int d0;
    prep(nreg, rd, rv, md);
    push_model(nreg);
    d0 = done_cnt;
    pulse_start();
    wait_done(d0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int n_reg; int rdly; int rvdly; int mode;
    int beats; int idx_wr; int sel_wr;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int d0, t;
    arst_n = 1'b0; cke = 1'b1; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
    vecs[0] = '{3,      0, 1, 0,  6,  3,  6};
    vecs[1] = '{0,      0, 1, 0,  0,  0,  0};
    vecs[2] = '{4,      2, 3, 1,  8,  4,  8};
    vecs[3] = '{'hFFFF, 0, 1, 0, 64, 32, 64};
    vecs[4] = '{1,      1, 2, 1,  2,  1,  2};
    vecs[5] = '{'h21,   $urandom_range(0, 2), $urandom_range(1, 3), 1, 64, 32, 64};

    // reset state
    step(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    check("rst_avalid", bus_if.m_avalid_o, 0);
    check("rst_addr", bus_if.m_addr_o, 0);
    check("rst_wdata", bus_if.m_wdata_o, 0);
    check("rst_wstrb", bus_if.m_wstrb_o, 0);
    check("rst_tvalid", bus_if.tvalid_o, 0);
    check("rst_tlast", bus_if.tlast_o, 0);
    check("rst_tdata", bus_if.tdata_o, 0);
    arst_n = 1'b1;
    step(2);

    // table-driven readouts
    for (int v = 0; v < 6; v++) begin
      run_readout(vecs[v].n_reg, vecs[v].rdly, vecs[v].rvdly, vecs[v].mode);
      check($sformatf("v%0d_beats", v), beats, vecs[v].beats);
      check($sformatf("v%0d_idx_wr", v), n_idx_wr, vecs[v].idx_wr);
      check($sformatf("v%0d_sel_wr", v), n_sel_wr, vecs[v].sel_wr);
    end

    // empty buffer: single read, done 3 cycles after start
    run_readout(0, 0, 1, 0);
    check("n0_latency", done_cyc - st_cyc, 3);
    check("n0_requests", n_req, 1);

    // start and abort together in IDLE: nothing happens
    prep(3, 0, 1, 0);
    d0 = done_cnt;
    start = 1'b1; abort = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    step(4);
    check("sa_busy", busy, 0);
    check("sa_done", done_cnt - d0, 0);
    check("sa_requests", n_req, 0);

    // abort during RD_DATA of sample 1 word 0
    prep(3, 0, 1, 0);
    exp_q.push_back({1'b0, mem[0][31:0]});
    exp_q.push_back({1'b0, mem[0][63:32]});
    exp_q.push_back({1'b0, mem[1][31:0]});
    d0 = done_cnt;
    pulse_start();
    t = 0;
    while (!(dbg_state == ST_RD_DATA && cur_idx == 1 && cur_sel == 0) && t < BUDGET) begin
      step(1); t++;
    end
    check("ab_reached", dbg_state, ST_RD_DATA);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    wait_done(d0);
    check("ab_beats", beats, 3);
    check("ab_requests", n_req, 9);
    check("ab_done_lat", done_cyc - hs_cyc, 1);

    // reset in the middle of PUSH
    prep(3, 0, 1, 2);
    d0 = done_cnt;
    pulse_start();
    t = 0;
    while (!bus_if.tvalid_o && t < BUDGET) begin step(1); t++; end
    check("rp_in_push", bus_if.tvalid_o, 1);
    arst_n = 1'b0;
    #1;
    check("rp_tvalid", bus_if.tvalid_o, 0);
    check("rp_avalid", bus_if.m_avalid_o, 0);
    check("rp_busy", busy, 0);
    step(2);
    arst_n = 1'b1;
    step(2);
    check("rp_busy_rel", busy, 0);
    check("rp_no_done", done_cnt - d0, 0);
    run_readout(2, 1, 1, 1);
    check("rp_beats", beats, 4);

    // clock enable low freezes the FSM and the abort flag
    prep(2, 0, 1, 0);
    push_model(2);
    slave_en = 1'b0;
    d0 = done_cnt;
    pulse_start();
    step(1);
    cke = 1'b0;
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(2);
    check("ck_state", dbg_state, ST_RD_N);
    check("ck_avalid", bus_if.m_avalid_o, 1);
    check("ck_addr", bus_if.m_addr_o, A_NS);
    check("ck_busy", busy, 1);
    cke = 1'b1;
    slave_en = 1'b1;
    wait_done(d0);
    check("ck_beats", beats, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
